// File: rtl/fft_wb_stream_adapter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fft_wb_stream_adapter_if                                      |
// | Purpose  : Bundles the Wishbone sample ports, the FFT core AXI-stream    |
// |            config/data/result channels and the core framing events used |
// |            by fft_wb_stream_adapter.                                     |
// | Modports : slave  - adapter view (Wishbone slave in, Wishbone master out,|
// |                     AXI master towards core input, AXI slave from core)  |
// |            master - environment view (drives the adapter inputs)         |
// | Signals  : DAT_I/WE_I/STB_I/CYC_I/ACK_O   input sample bus              |
// |            INV_I/SCALE_I                   per-frame core configuration  |
// |            DAT_O/STB_O/CYC_O/WE_O/ACK_I    output sample bus             |
// |            ERR_O                           sticky framing error          |
// |            core_rstn, cfg_*, s_*, m_*      FFT core side                 |
// |            ev_tlast_unexp/ev_tlast_miss    core framing events           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface fft_wb_stream_adapter_if #(
  parameter int DW    = 16,
  parameter int CFG_W = 16
);
  logic [2*DW-1:0]  DAT_I;
  logic             WE_I;
  logic             STB_I;
  logic             CYC_I;
  logic             ACK_O;
  logic             INV_I;
  logic [CFG_W-2:0] SCALE_I;
  logic [2*DW-1:0]  DAT_O;
  logic             STB_O;
  logic             CYC_O;
  logic             WE_O;
  logic             ACK_I;
  logic             ERR_O;
  logic             core_rstn;
  logic [CFG_W-1:0] cfg_tdata;
  logic             cfg_tvalid;
  logic             cfg_tready;
  logic [2*DW-1:0]  s_tdata;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;
  logic [2*DW-1:0]  m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic             ev_tlast_unexp;
  logic             ev_tlast_miss;

  modport slave (
    input  DAT_I, WE_I, STB_I, CYC_I, INV_I, SCALE_I, ACK_I,
    input  cfg_tready, s_tready, m_tdata, m_tvalid, m_tlast,
    input  ev_tlast_unexp, ev_tlast_miss,
    output ACK_O, DAT_O, STB_O, CYC_O, WE_O, ERR_O, core_rstn,
    output cfg_tdata, cfg_tvalid, s_tdata, s_tvalid, s_tlast, m_tready
  );

  modport master (
    output DAT_I, WE_I, STB_I, CYC_I, INV_I, SCALE_I, ACK_I,
    output cfg_tready, s_tready, m_tdata, m_tvalid, m_tlast,
    output ev_tlast_unexp, ev_tlast_miss,
    input  ACK_O, DAT_O, STB_O, CYC_O, WE_O, ERR_O, core_rstn,
    input  cfg_tdata, cfg_tvalid, s_tdata, s_tvalid, s_tlast, m_tready
  );
endinterface
`default_nettype wire

// File: rtl/fft_wb_stream_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fft_wb_stream_adapter                                         |
// | Purpose  : Wishbone <-> AXI-stream adapter around an FFT/IFFT core.      |
// |            Counts N input samples per frame and marks s_tlast, issues   |
// |            one config word per frame, buffers core results in a small   |
// |            first-word-fall-through FIFO whose head is the registered    |
// |            DAT_O/STB_O stage, tracks frames in flight to close CYC_O    |
// |            and flags core framing errors.                                |
// | Ports    : CLK_I  clock                                                  |
// |            RST_I  synchronous active-high reset                          |
// |            bus    fft_wb_stream_adapter_if.slave (all bus/core signals)  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fft_wb_stream_adapter #(
  parameter int DW        = 16,
  parameter int LOG2_N    = 8,
  parameter int CFG_W     = 16,
  parameter int FIFO_LOG2 = 2
) (
  input wire                     CLK_I,
  input wire                     RST_I,
  fft_wb_stream_adapter_if.slave bus
);

  localparam int                   c_N         = 1 << LOG2_N;
  localparam int                   c_DEPTH     = 1 << FIFO_LOG2;
  localparam logic [LOG2_N-1:0]    c_IN_LAST   = LOG2_N'(c_N - 1);
  // The head register holds one entry, so the memory behind it holds DEPTH-1.
  localparam logic [FIFO_LOG2-1:0] c_MEM_FULL  = FIFO_LOG2'(c_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t               r_state;
  logic [LOG2_N-1:0]    r_in_cnt;
  logic [CFG_W-1:0]     r_cfg_tdata;
  logic                 r_cfg_tvalid;

  logic [2*DW:0]        r_mem [c_DEPTH];
  logic [FIFO_LOG2-1:0] r_rd_ptr;
  logic [FIFO_LOG2-1:0] r_wr_ptr;
  logic [FIFO_LOG2-1:0] r_fill;
  logic [2*DW-1:0]      r_dat_o;
  logic                 r_last_o;
  logic                 r_stb_o;

  logic [LOG2_N-1:0]    r_frm_cnt;
  logic                 r_cyc_o;
  logic                 r_err_o;

  logic                 w_req;
  logic                 w_s_tvalid;
  logic                 w_accept;
  logic                 w_in_last;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_m_tready;
  logic                 w_push;
  logic                 w_head_free;
  logic                 w_load_mem;
  logic                 w_load_byp;
  logic                 w_mem_wr;
  logic [2*DW:0]        w_mem_head;
  logic                 w_empty_nxt;
  logic                 w_frm_inc;
  logic                 w_frm_dec;
  logic [LOG2_N-1:0]    w_frm_nxt;

  // ---------------------------------------------------------------- input side
  assign w_req      = bus.CYC_I & bus.STB_I & bus.WE_I;
  assign w_s_tvalid = (r_state == S_DATA) & w_req & ~RST_I;
  assign w_accept   = w_s_tvalid & bus.s_tready;
  assign w_in_last  = (r_in_cnt == c_IN_LAST);

  // Dropping CYC_I mid-frame simply removes req; state and count are held,
  // so the frame resumes without a fresh config word.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state      <= S_IDLE;
      r_in_cnt     <= '0;
      r_cfg_tdata  <= '0;
      r_cfg_tvalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // bit0 = 1 selects the forward transform on the core
            r_cfg_tdata  <= {bus.SCALE_I, ~bus.INV_I};
            r_cfg_tvalid <= 1'b1;
            r_state      <= S_CFG;
          end
        end
        S_CFG: begin
          if (bus.cfg_tready) begin
            r_cfg_tvalid <= 1'b0;
            r_state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_in_cnt <= w_in_last ? '0 : r_in_cnt + LOG2_N'(1);
            if (w_in_last) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- output FIFO
  assign w_pop       = r_stb_o & bus.ACK_I;
  assign w_full      = r_stb_o & (r_fill == c_MEM_FULL);
  assign w_m_tready  = ~RST_I & (~w_full | w_pop);
  assign w_push      = bus.m_tvalid & w_m_tready;
  assign w_head_free = ~r_stb_o | w_pop;
  assign w_mem_head  = r_mem[r_rd_ptr];
  // Head refills from memory first; with memory empty a new word bypasses
  // straight into the head, giving one cycle from core handshake to STB_O.
  assign w_load_mem  = w_head_free & (r_fill != '0);
  assign w_load_byp  = w_head_free & (r_fill == '0) & w_push;
  assign w_mem_wr    = w_push & ~w_load_byp;
  assign w_empty_nxt = w_head_free & (r_fill == '0) & ~w_push;

  always_ff @(posedge CLK_I) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr] <= {bus.m_tlast, bus.m_tdata};
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_dat_o  <= '0;
      r_last_o <= 1'b0;
      r_stb_o  <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_load_mem) begin
        r_dat_o  <= w_mem_head[2*DW-1:0];
        r_last_o <= w_mem_head[2*DW];
        r_stb_o  <= 1'b1;
        r_rd_ptr <= r_rd_ptr + FIFO_LOG2'(1);
      end else if (w_load_byp) begin
        r_dat_o  <= bus.m_tdata;
        r_last_o <= bus.m_tlast;
        r_stb_o  <= 1'b1;
      end else if (w_pop) begin
        r_stb_o  <= 1'b0;       // DAT_O keeps the last word
      end
      if (w_mem_wr) begin
        r_wr_ptr <= r_wr_ptr + FIFO_LOG2'(1);
      end
      r_fill <= r_fill + FIFO_LOG2'(w_mem_wr) - FIFO_LOG2'(w_load_mem);
    end
  end

  // ------------------------------------------------- frames in flight / CYC_O
  assign w_frm_inc = w_accept & w_in_last;
  assign w_frm_dec = w_pop & r_last_o;

  always_comb begin
    w_frm_nxt = r_frm_cnt;
    if (w_frm_inc & ~w_frm_dec) begin
      w_frm_nxt = r_frm_cnt + LOG2_N'(1);
    end else if (~w_frm_inc & w_frm_dec) begin
      w_frm_nxt = r_frm_cnt - LOG2_N'(1);
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_frm_cnt <= '0;
      r_cyc_o   <= 1'b0;
      r_err_o   <= 1'b0;
    end else begin
      r_frm_cnt <= w_frm_nxt;
      // Close the output cycle only once the last owed frame has fully left
      // and the upstream master has released its own cycle.
      if (w_push) begin
        r_cyc_o <= 1'b1;
      end else if (w_frm_dec && (w_frm_nxt == '0) && w_empty_nxt && !bus.CYC_I) begin
        r_cyc_o <= 1'b0;
      end
      if (bus.ev_tlast_unexp | bus.ev_tlast_miss) begin
        r_err_o <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------ outputs
  assign bus.core_rstn  = ~RST_I;
  assign bus.cfg_tdata  = r_cfg_tdata;
  assign bus.cfg_tvalid = r_cfg_tvalid;
  assign bus.s_tdata    = bus.DAT_I;
  assign bus.s_tvalid   = w_s_tvalid;
  assign bus.s_tlast    = w_in_last & ~RST_I;
  assign bus.ACK_O      = w_accept;
  assign bus.m_tready   = w_m_tready;
  assign bus.DAT_O      = r_dat_o;
  assign bus.STB_O      = r_stb_o;
  assign bus.WE_O       = r_stb_o;
  assign bus.CYC_O      = r_cyc_o;
  assign bus.ERR_O      = r_err_o;

endmodule
`default_nettype wire

// File: tb/tb_fft_wb_stream_adapter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fft_wb_stream_adapter                                      |
// | Purpose  : Self-checking bench for fft_wb_stream_adapter. A behavioural  |
// |            FFT core stand-in (frame of N samples in, bit-inverted frame |
// |            out) and a downstream sink surround the adapter; expected    |
// |            outputs come from queues filled by the input driver.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fft_wb_stream_adapter;
  localparam int DW = 16, LOG2_N = 8, CFG_W = 16, FIFO_LOG2 = 2;
  localparam int N  = 1 << LOG2_N;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fft_wb_stream_adapter_if #(.DW(DW), .CFG_W(CFG_W)) bus ();

  fft_wb_stream_adapter #(
    .DW(DW), .LOG2_N(LOG2_N), .CFG_W(CFG_W), .FIFO_LOG2(FIFO_LOG2)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .bus  (bus)
  );

  // Reference state
  logic [31:0] exp_out[$];   // expected DAT_O words, in order
  logic [15:0] exp_cfg[$];   // expected config words, in order
  logic [31:0] core_in[$];   // core stand-in: current input frame
  logic [32:0] core_out[$];  // core stand-in: {tlast, data} results
  bit cfg_pending  = 0;
  bit m_done       = 0;
  bit sink_hold    = 0;
  bit sink_always  = 0;
  bit check_close  = 0;
  bit close_pending = 0;
  int pops = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // FFT core stand-in: random ready on input/config, random valid on output.
  initial begin : core_model
    logic [32:0] ent;
    bus.cfg_tready = 1'b0;
    bus.s_tready   = 1'b0;
    bus.m_tvalid   = 1'b0;
    bus.m_tdata    = '0;
    bus.m_tlast    = 1'b0;
    forever begin
      @(negedge clk);
      if (m_done) begin
        bus.m_tvalid = 1'b0;
        m_done = 0;
      end
      bus.cfg_tready = 1'($urandom_range(0, 1));
      bus.s_tready   = ($urandom_range(0, 3) != 0);
      if (!bus.m_tvalid && core_out.size() > 0 && $urandom_range(0, 3) != 0) begin
        ent = core_out.pop_front();
        bus.m_tdata  = ent[31:0];
        bus.m_tlast  = ent[32];
        bus.m_tvalid = 1'b1;
      end
      #3;
      if (rst) begin
        core_in.delete();
        core_out.delete();
        cfg_pending  = 0;
        bus.m_tvalid = 1'b0;
        m_done       = 0;
      end else begin
        if (bus.cfg_tvalid && bus.cfg_tready) begin
          chk("cfg_expected", 64'(exp_cfg.size() > 0), 64'd1);
          if (exp_cfg.size() > 0) chk("cfg_tdata", 64'(bus.cfg_tdata), 64'(exp_cfg.pop_front()));
          cfg_pending = 1;
        end
        if (bus.s_tvalid && bus.s_tready) begin
          if (core_in.size() == 0) begin
            chk("cfg_before_s0", 64'(cfg_pending), 64'd1);
            cfg_pending = 0;
          end
          chk("s_tlast", 64'(bus.s_tlast), (core_in.size() == N - 1) ? 64'd1 : 64'd0);
          core_in.push_back(bus.s_tdata);
          if (core_in.size() == N) begin
            for (int i = 0; i < N; i++) core_out.push_back({(i == N - 1), ~core_in[i]});
            core_in.delete();
          end
        end
        if (bus.m_tvalid && bus.m_tready) m_done = 1;
      end
    end
  end

  // Downstream sink and output scoreboard.
  initial begin : sink
    bus.ACK_I = 1'b0;
    forever begin
      @(negedge clk);
      bus.ACK_I = sink_hold ? 1'b0 : (sink_always ? 1'b1 : ($urandom_range(0, 3) != 0));
      #3;
      if (close_pending) begin
        chk("cyc_o_fall", 64'(bus.CYC_O), 64'd0);
        close_pending = 0;
      end
      if (!rst && bus.STB_O && bus.ACK_I) begin
        chk("cyc_o_with_stb", 64'(bus.CYC_O), 64'd1);
        chk("we_o", 64'(bus.WE_O), 64'd1);
        if (exp_out.size() == 0) chk("out_expected", 64'(exp_out.size()), 64'd1);
        else chk("dat_o", 64'(bus.DAT_O), 64'(exp_out.pop_front()));
        pops++;
        if (check_close && exp_out.size() == 0) close_pending = 1;
      end
    end
  end

  // Send n samples as one Wishbone burst. CYC_I/STB_I drop for drop_len cycles
  // when drop_at samples have been accepted; INV_I toggles once at inv_at.
  task automatic send(input int n, input int drop_at, input int drop_len,
                      input int inv_at, input bit keep);
    logic [31:0] smp;
    int k = 0, gap = 0, budget = 0;
    bit first = 1, toggled = 0;
    smp = $urandom;
    while (k < n) begin
      @(negedge clk);
      budget++;
      if (budget > 20000) begin
        chk("send_timeout", 64'(k), 64'(n));
        break;
      end
      if (k == drop_at && gap < drop_len) begin
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        gap++;
        #3;
        chk("ack_o_idle", 64'(bus.ACK_O), 64'd0);
      end else begin
        if (first) begin
          exp_cfg.push_back({bus.SCALE_I, ~bus.INV_I});
          first = 0;
        end
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b1;
        bus.DAT_I = smp;
        if (k == inv_at && !toggled) begin
          bus.INV_I = ~bus.INV_I;
          toggled = 1;
        end
        #3;
        if (bus.ACK_O) begin
          exp_out.push_back(~smp);
          k++;
          smp = $urandom;
        end
      end
    end
    if (!keep) begin
      @(negedge clk);
      bus.CYC_I = 1'b0;
      bus.STB_I = 1'b0;
      bus.WE_I  = 1'b0;
    end
  endtask

  task automatic wait_drain(input bit hold_chk);
    int t = 0;
    bit seen = 0;
    while (exp_out.size() != 0) begin
      @(negedge clk);
      #3;
      t++;
      if (hold_chk) begin
        if (bus.STB_O) seen = 1;
        if (seen) chk("cyc_o_hold", 64'(bus.CYC_O), 64'd1);
      end
      if (t > 20000) begin
        chk("drain_timeout", 64'(exp_out.size()), 64'd0);
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack_o"},      64'(bus.ACK_O),      64'd0);
    chk({tag, "_stb_o"},      64'(bus.STB_O),      64'd0);
    chk({tag, "_cyc_o"},      64'(bus.CYC_O),      64'd0);
    chk({tag, "_we_o"},       64'(bus.WE_O),       64'd0);
    chk({tag, "_err_o"},      64'(bus.ERR_O),      64'd0);
    chk({tag, "_dat_o"},      64'(bus.DAT_O),      64'd0);
    chk({tag, "_cfg_tvalid"}, 64'(bus.cfg_tvalid), 64'd0);
    chk({tag, "_cfg_tdata"},  64'(bus.cfg_tdata),  64'd0);
    chk({tag, "_s_tvalid"},   64'(bus.s_tvalid),   64'd0);
    chk({tag, "_s_tlast"},    64'(bus.s_tlast),    64'd0);
    chk({tag, "_m_tready"},   64'(bus.m_tready),   64'd0);
    chk({tag, "_core_rstn"},  64'(bus.core_rstn),  64'd0);
  endtask

  initial begin : stimulus
    int p0, t;
    rst = 1'b1;
    bus.DAT_I = '0; bus.WE_I = 1'b0; bus.STB_I = 1'b0; bus.CYC_I = 1'b0;
    bus.INV_I = 1'b0; bus.SCALE_I = '0;
    bus.ev_tlast_unexp = 1'b0; bus.ev_tlast_miss = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("core_rstn_run", 64'(bus.core_rstn), 64'd1);

    // 1: forward frame, downstream always ready, CYC_O closes after last pop
    bus.INV_I = 1'b0;
    bus.SCALE_I = 15'($urandom);
    sink_always = 1;
    check_close = 1;
    send(N, -1, 0, -1, 0);
    wait_drain(0);
    check_close = 0;
    sink_always = 0;
    chk("t1_cfg_consumed", 64'(exp_cfg.size()), 64'd0);

    // 2: IFFT with scale 0x15 (cfg 0x002A), INV dropped mid-frame (cfg 0x002B next)
    bus.INV_I = 1'b1;
    bus.SCALE_I = 15'h15;
    send(N, -1, 0, 128, 1);
    send(N, -1, 0, -1, 0);
    wait_drain(0);
    chk("t2_cfg_consumed", 64'(exp_cfg.size()), 64'd0);

    // 3: downstream stalls 40 cycles mid-output; FIFO fills and backpressures
    bus.SCALE_I = 15'($urandom);
    send(N, -1, 0, -1, 0);
    p0 = pops;
    t = 0;
    while (pops < p0 + 100 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("t3_reached_stall_point", 64'(pops >= p0 + 100), 64'd1);
    sink_hold = 1;
    repeat (40) @(negedge clk);
    #3;
    chk("t3_m_tready_full", 64'(bus.m_tready), 64'd0);
    chk("t3_stb_o_held", 64'(bus.STB_O), 64'd1);
    chk("t3_cyc_o_held", 64'(bus.CYC_O), 64'd1);
    sink_hold = 0;
    wait_drain(0);

    // 4: two frames back-to-back with CYC_I high throughout
    send(N, -1, 0, -1, 1);
    send(N, -1, 0, -1, 1);
    @(negedge clk);
    bus.STB_I = 1'b0;
    wait_drain(1);
    bus.CYC_I = 1'b0;
    bus.WE_I  = 1'b0;

    // 5: CYC_I dropped for 10 cycles at sample 100
    send(N, 100, 10, -1, 0);
    wait_drain(0);
    chk("t5_cfg_consumed", 64'(exp_cfg.size()), 64'd0);

    // 6: framing error is sticky; reset mid-frame clears everything
    @(negedge clk);
    bus.ev_tlast_miss = 1'b1;
    @(negedge clk);
    bus.ev_tlast_miss = 1'b0;
    #3;
    chk("t6_err_set", 64'(bus.ERR_O), 64'd1);
    send(50, -1, 0, -1, 1);
    #1;
    chk("t6_err_sticky", 64'(bus.ERR_O), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    @(negedge clk);
    #3;
    chk_all_zero("t6_reset");
    exp_out.delete();
    exp_cfg.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    chk("t6_err_cleared", 64'(bus.ERR_O), 64'd0);
    send(N, -1, 0, -1, 0);
    wait_drain(0);
    chk("t6_cfg_consumed", 64'(exp_cfg.size()), 64'd0);
    chk("t6_err_still_clear", 64'(bus.ERR_O), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
